// File: rtl/msrv_32_pkg.sv
// Shared constants and types for the msrv_32 data-memory write path.
package msrv_32_pkg;

    // Store-unit FSM encoding
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;

    // Store size codes (funct3[1:0]); 2'b11 falls through to word
    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    // Byte-enable patterns
    localparam logic [3:0] MASK_B0  = 4'b0001;
    localparam logic [3:0] MASK_HLO = 4'b0011;
    localparam logic [3:0] MASK_HHI = 4'b1100;
    localparam logic [3:0] MASK_W   = 4'b1111;

    // One captured store as it is presented on the bus
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } store_t;

endpackage

// File: rtl/msrv_32_store_lane_gen.sv
// Byte-lane steering for stores: size + low address bits -> byte enables and
// lane-replicated data. Misaligned halfword/word requests never reach here,
// so a[0] is ignored for halfwords and a[1:0] for words.
module msrv_32_store_lane_gen
    import msrv_32_pkg::*;
(
    input  logic [1:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rs2,
    output logic [3:0]  o_mask,
    output logic [31:0] o_data
);

    // Replicate the source bytes into every lane and pick the enables
    always_comb begin
        o_mask = MASK_W;
        o_data = i_rs2;
        case (i_funct3)
            SZ_B: begin
                o_mask = MASK_B0 << i_addr_lo;
                o_data = {4{i_rs2[7:0]}};
            end
            SZ_H: begin
                o_mask = i_addr_lo[1] ? MASK_HHI : MASK_HLO;
                o_data = {2{i_rs2[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/msrv_32_store_unit.sv
// Data-memory write port: captures one store from the decoder, holds it on
// the bus until ack, stalls the pipeline meanwhile, and gives up with a
// one-cycle bus_err_out pulse after TIMEOUT unacknowledged request cycles.
module msrv_32_store_unit
    import msrv_32_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        mem_wr_req_in,
    input  logic [1:0]  funct3_in,
    input  logic [31:0] iadder_in,
    input  logic [31:0] rs2_in,
    input  logic        dm_ack_in,
    output logic        dm_wr_req_out,
    output logic [31:0] dm_addr_out,
    output logic [31:0] dm_data_out,
    output logic [3:0]  dm_wr_mask_out,
    output logic        stall_out,
    output logic        bus_err_out
);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    store_t           r_st;
    logic             r_bus_err;

    logic             w_in_req;
    logic             w_capture;
    logic             w_timeout;
    logic             w_done;
    logic [3:0]       w_mask;
    logic [31:0]      w_data;

    msrv_32_store_lane_gen u_lane_gen (
        .i_funct3  (funct3_in),
        .i_addr_lo (iadder_in[1:0]),
        .i_rs2     (rs2_in),
        .o_mask    (w_mask),
        .o_data    (w_data)
    );

    assign w_in_req  = (r_state == ST_REQ);
    assign w_capture = (r_state == ST_IDLE) && mem_wr_req_in;
    // Ack has priority: a timeout only counts when the bus stayed silent
    assign w_timeout = w_in_req && !dm_ack_in && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_done    = w_in_req && (dm_ack_in || w_timeout);

    // IDLE -> REQ on capture, back to IDLE on ack or timeout
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)        r_state <= ST_IDLE;
        else if (w_capture) r_state <= ST_REQ;
        else if (w_done)    r_state <= ST_IDLE;
    end

    // Count unacknowledged request cycles; cleared on every new capture
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                r_cnt <= '0;
        else if (w_capture)         r_cnt <= '0;
        else if (w_in_req && !w_done) r_cnt <= r_cnt + 1'b1;
    end

    // Bus payload is latched once per store and held until the next capture
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)        r_st <= '0;
        else if (w_capture) r_st <= '{addr: {iadder_in[31:2], 2'b00}, data: w_data, mask: w_mask};
    end

    // Error pulse lands the cycle after the abort
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) r_bus_err <= 1'b0;
        else         r_bus_err <= w_timeout;
    end

    assign dm_wr_req_out  = w_in_req;
    assign dm_addr_out    = r_st.addr;
    assign dm_data_out    = r_st.data;
    assign dm_wr_mask_out = r_st.mask;
    assign bus_err_out    = r_bus_err;
    // Gated by reset so every output reads 0 while reset is held
    assign stall_out      = rst_in && (w_capture || (w_in_req && !w_done));

endmodule
